// File: rtl/pipeline_pkg.sv
// pipeline_pkg: control-word struct and encodings shared by the pipelined RV32I stages.
package pipeline_pkg;
    typedef struct packed {
        logic [1:0] result_src;
        logic       mem_write;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic       reg_write;
        logic       byte_addr;
        logic [1:0] jump_type;
        logic [1:0] branch_type;
    } ctrl_t;

    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_BEQ   = 2'b01;
    localparam logic [1:0] BR_BNE   = 2'b10;
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_IMM  = 2'b11;

    localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/bubble_counter.sv
// bubble_counter: saturating up-counter with enable and async active-low reset.
module bubble_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_cnt <= '0;
        else if (i_en && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;

    assign o_cnt = r_cnt;
endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: decode-to-execute pipeline register with stall, flush and valid tracking.
// Define ID_EX_PERF_CNT_EN to add the saturating BubbleCntE counter port.
module id_ex_register
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic [2:0]      ALUctrlD,
    input  logic            ALUsrcD,
    input  logic            RegWriteD,
    input  logic            ByteAddrD,
    input  logic [1:0]      JumpTypeD,
    input  logic [1:0]      BranchTypeD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [4:0]      RdD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic [2:0]      ALUctrlE,
    output logic            ALUsrcE,
    output logic            RegWriteE,
    output logic            ByteAddrE,
    output logic [1:0]      JumpTypeE,
    output logic [1:0]      BranchTypeE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      RdE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic            ValidE
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     BubbleCntE
`endif
);
    ctrl_t           w_ctrl_d, r_ctrl;
    logic [XLEN-1:0] r_rd1, r_rd2, r_pc, r_pc4, r_imm;
    logic [4:0]      r_rd, r_rs1, r_rs2;
    logic            r_valid;
    logic            w_bubble, w_en;

    assign w_ctrl_d = {ResultSrcD, MemWriteD, ALUctrlD, ALUsrcD, RegWriteD, ByteAddrD, JumpTypeD, BranchTypeD};
    // Flush overrides stall; an invalid decode slot becomes a bubble unless stalled.
    assign w_bubble = FlushE || (!StallE && !ValidD);
    assign w_en     = FlushE || !StallE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_ctrl  <= CTRL_BUBBLE;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_imm   <= '0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_valid <= 1'b0;
        end else if (w_en) begin
            r_ctrl  <= w_bubble ? CTRL_BUBBLE : w_ctrl_d;
            r_rd1   <= w_bubble ? '0 : RD1D;
            r_rd2   <= w_bubble ? '0 : RD2D;
            r_pc    <= w_bubble ? '0 : PCD;
            r_pc4   <= w_bubble ? '0 : PCPlus4D;
            r_imm   <= w_bubble ? '0 : ImmExtD;
            r_rd    <= w_bubble ? '0 : RdD;
            r_rs1   <= w_bubble ? '0 : Rs1D;
            r_rs2   <= w_bubble ? '0 : Rs2D;
            r_valid <= !w_bubble;
        end

    assign {ResultSrcE, MemWriteE, ALUctrlE, ALUsrcE, RegWriteE, ByteAddrE, JumpTypeE, BranchTypeE} = r_ctrl;
    assign RD1E     = r_rd1;
    assign RD2E     = r_rd2;
    assign PCE      = r_pc;
    assign PCPlus4E = r_pc4;
    assign ImmExtE  = r_imm;
    assign RdE      = r_rd;
    assign Rs1E     = r_rs1;
    assign Rs2E     = r_rs2;
    assign ValidE   = r_valid;

`ifdef ID_EX_PERF_CNT_EN
    bubble_counter #(.W(32)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_bubble),
        .o_cnt (BubbleCntE)
    );
`endif
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: directed stimulus with a queue scoreboard checked at each falling edge.
module tb_id_ex_register;
    import pipeline_pkg::*;

    typedef struct packed {
        ctrl_t       c;
        logic [31:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  rd, rs1, rs2;
        logic        v;
    } vec_t;

    logic clk, rst_n, StallE, FlushE, ValidD;
    logic [1:0] ResultSrcD, JumpTypeD, BranchTypeD, ResultSrcE, JumpTypeE, BranchTypeE;
    logic [2:0] ALUctrlD, ALUctrlE;
    logic MemWriteD, ALUsrcD, RegWriteD, ByteAddrD, MemWriteE, ALUsrcE, RegWriteE, ByteAddrE, ValidE;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD, RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0] RdD, Rs1D, Rs2D, RdE, Rs1E, Rs2E;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] BubbleCntE, exp_cnt;
    logic [31:0] cnt_q[$];
`endif

    vec_t d, act, Z, F, A, B, C, e;
    vec_t exp_q[$];
    string tag_q[$];
    int checks = 0, errors = 0;

    assign {ResultSrcD, MemWriteD, ALUctrlD, ALUsrcD, RegWriteD, ByteAddrD, JumpTypeD, BranchTypeD,
            RD1D, RD2D, PCD, PCPlus4D, ImmExtD, RdD, Rs1D, Rs2D, ValidD} = d;
    assign act = {ResultSrcE, MemWriteE, ALUctrlE, ALUsrcE, RegWriteE, ByteAddrE, JumpTypeE, BranchTypeE,
                  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, RdE, Rs1E, Rs2E, ValidE};

    id_ex_register #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .ALUctrlD(ALUctrlD), .ALUsrcD(ALUsrcD),
        .RegWriteD(RegWriteD), .ByteAddrD(ByteAddrD), .JumpTypeD(JumpTypeD), .BranchTypeD(BranchTypeD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .ALUctrlE(ALUctrlE), .ALUsrcE(ALUsrcE),
        .RegWriteE(RegWriteE), .ByteAddrE(ByteAddrE), .JumpTypeE(JumpTypeE), .BranchTypeE(BranchTypeE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .ValidE(ValidE)
`ifdef ID_EX_PERF_CNT_EN
        , .BubbleCntE(BubbleCntE)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    always @(negedge clk)
        if (exp_q.size() != 0) begin
            vec_t x;
            string t;
            x = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== x) begin
                errors++;
                $display("FAIL %s: outputs got %h required %h", t, act, x);
            end
`ifdef ID_EX_PERF_CNT_EN
            begin
                logic [31:0] xc;
                xc = cnt_q.pop_front();
                checks++;
                if (BubbleCntE !== xc) begin
                    errors++;
                    $display("FAIL %s_cnt: BubbleCntE got %h required %h", t, BubbleCntE, xc);
                end
            end
`endif
        end

    task automatic cyc(input string tag, input logic st, input logic fl, input vec_t ex, input logic rst_mid);
        StallE = st;
        FlushE = fl;
        @(posedge clk);
`ifdef ID_EX_PERF_CNT_EN
        if (!rst_n || rst_mid)
            exp_cnt = 32'h0;
        else if ((fl || (!st && !d.v)) && exp_cnt != 32'hFFFF_FFFF)
            exp_cnt = exp_cnt + 1;
        cnt_q.push_back(exp_cnt);
`endif
        exp_q.push_back(ex);
        tag_q.push_back(tag);
        #2;
        if (rst_mid) rst_n = 1'b0;
    endtask

    initial begin
        Z = '0;
        F = '{c: '{RES_MEM, 1'b1, 3'b101, 1'b1, 1'b1, 1'b1, JMP_JALR, BR_BNE},
              rd1: 32'hDEAD_BEEF, rd2: 32'h1234_5678, pc: 32'h0000_0100, pc4: 32'h0000_0104,
              imm: 32'hFFFF_F800, rd: 5'd31, rs1: 5'd17, rs2: 5'd3, v: 1'b1};
`ifdef ID_EX_PERF_CNT_EN
        exp_cnt = 32'h0;
`endif
        rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        d = F;
        cyc("reset", 0, 0, Z, 0);
        rst_n = 1'b1;

        d = Z; d.c.reg_write = 1'b1; d.rd1 = 32'h5; d.rd = 5'd7; d.v = 1'b1;
        e = Z; e.c.reg_write = 1'b1; e.rd1 = 32'h5; e.rd = 5'd7; e.v = 1'b1;
        cyc("basic", 0, 0, e, 0);
        d = F;
        cyc("full", 0, 0, F, 0);
        d = F; d.v = 1'b0;
        cyc("invalid", 0, 0, Z, 0);

        A = Z; A.pc = 32'h10; A.pc4 = 32'h14; A.c.reg_write = 1'b1; A.c.branch_type = BR_BEQ; A.rd = 5'd5; A.v = 1'b1;
        d = A;
        cyc("stallA", 0, 0, A, 0);
        B = A; B.pc = 32'h14; B.pc4 = 32'h18;
        d = B;
        for (int i = 0; i < 3; i++) cyc("stall", 1, 0, A, 0);
        cyc("unstall", 0, 0, B, 0);

        d = F; d.c.mem_write = 1'b1; d.c.jump_type = JMP_JAL;
        cyc("flush_stall", 1, 1, Z, 0);
        d = F;
        cyc("refill", 0, 0, F, 0);
        cyc("flush", 0, 1, Z, 0);
        d = A;
        cyc("capA", 0, 0, A, 0);
        d.v = 1'b0;
        cyc("stall_invalid", 1, 0, A, 0);

        C = Z; C.pc = 32'h40; C.c.result_src = RES_PC4; C.c.jump_type = JMP_JAL; C.rd = 5'd1; C.v = 1'b1;
        d = C;
        cyc("pc40", 0, 0, C, 0);
        cyc("async_rst", 1, 0, Z, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        d.v = 1'b0;
        cyc("post_rst", 0, 0, Z, 0);
        d = C;
        cyc("recap", 0, 0, C, 0);

`ifdef ID_EX_PERF_CNT_EN
        @(negedge clk);
        #1 force dut.u_bubble_cnt.r_cnt = 32'hFFFF_FFFE;
        #1 release dut.u_bubble_cnt.r_cnt;
        exp_cnt = 32'hFFFF_FFFE;
        d = F;
        cyc("sat1", 0, 1, Z, 0);
        cyc("sat2", 0, 1, Z, 0);
        cyc("sat_stall", 1, 0, Z, 0);
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending got %0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
